// File: rtl/prim_unit_packer_pkg.sv
// prim_unit_packer_pkg: shared types and unit-mask helpers for the unit packer
package prim_unit_packer_pkg;
  localparam int MaxU = 64;
  typedef enum logic {FlushIdle, FlushSend} flush_st_e;
  function automatic int unit_popcount(input logic [MaxU-1:0] m);
    unit_popcount = 0;
    for (int i = 0; i < MaxU; i++) unit_popcount += int'(m[i]);
  endfunction
  function automatic int lowest_set_idx(input logic [MaxU-1:0] m);
    lowest_set_idx = 0;
    for (int i = MaxU - 1; i >= 0; i--) if (m[i]) lowest_set_idx = i;
  endfunction
endpackage

// File: rtl/prim_unit_packer_align.sv
// prim_unit_packer_align: LSB-justifies an input fragment and merges it above the stored units
module prim_unit_packer_align import prim_unit_packer_pkg::*; #(
  parameter int InW = 32,
  parameter int UnitW = 8,
  parameter int StoreU = 12,
  parameter int PtrW = 4,
  localparam int NIn = InW / UnitW
) (
  input  logic [InW-1:0]          data_i,
  input  logic [NIn-1:0]          mask_i,
  input  logic [PtrW-1:0]         pos_i,
  input  logic [StoreU*UnitW-1:0] store_i,
  output logic [StoreU*UnitW-1:0] merged_o,
  output logic [PtrW-1:0]         n_in_o
);
  localparam int SW = StoreU * UnitW;
  logic [InW-1:0] keep;
  logic [SW-1:0] frag, therm;
  // Drop invalid units, shift the run down to unit 0, trim to n_in units, then place at pos_i
  always_comb begin
    keep = '0;
    therm = '0;
    for (int u = 0; u < NIn; u++) keep[u*UnitW +: UnitW] = {UnitW{mask_i[u]}};
    n_in_o = PtrW'(unit_popcount(MaxU'(mask_i)));
    for (int u = 0; u < StoreU; u++) therm[u*UnitW +: UnitW] = {UnitW{u < int'(n_in_o)}};
    frag = (SW'(data_i & keep) >> (lowest_set_idx(MaxU'(mask_i)) * UnitW)) & therm;
    merged_o = store_i | (frag << (int'(pos_i) * UnitW));
  end
endmodule

// File: rtl/prim_unit_packer.sv
// prim_unit_packer: packs unit-granular fragments into OutW words; PRIM_UNIT_PACKER_MASK_CHECK_EN adds a sticky mask-contiguity error
module prim_unit_packer import prim_unit_packer_pkg::*; #(
  parameter int InW = 32,
  parameter int OutW = 32,
  parameter int UnitW = 8,
  parameter int Depth = 2,
  localparam int NIn = InW / UnitW,
  localparam int NOut = OutW / UnitW,
  localparam int CntW = $clog2(NOut + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic [InW-1:0]  data_i,
  input  logic [NIn-1:0]  mask_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [OutW-1:0] data_o,
  output logic [NOut-1:0] mask_o,
  output logic [CntW-1:0] cnt_o,
  input  logic            ready_i,
  input  logic            flush_i,
  output logic            flush_done_o,
  output logic            empty_o,
  output logic            err_o
);
  localparam int StoreU = NIn + Depth * NOut;
  localparam int PtrW = $clog2(StoreU + 1);
  localparam int SW = StoreU * UnitW;
  flush_st_e fsm_q;
  logic [PtrW-1:0] pos_q, n_in, cnt_full, out_u;
  logic [SW-1:0] store_q, merged;
  logic ack_in, ack_out;
  prim_unit_packer_align #(
    .InW(InW), .UnitW(UnitW), .StoreU(StoreU), .PtrW(PtrW)
  ) u_align (
    .data_i(data_i), .mask_i(mask_i), .pos_i(pos_q), .store_i(store_q),
    .merged_o(merged), .n_in_o(n_in)
  );
  assign ready_o = fsm_q == FlushIdle && pos_q <= PtrW'(Depth * NOut);
  assign valid_o = pos_q >= PtrW'(NOut) || (fsm_q == FlushSend && pos_q != '0);
  assign ack_in = valid_i && ready_o;
  assign ack_out = valid_o && ready_i;
  assign cnt_full = pos_q >= PtrW'(NOut) ? PtrW'(NOut) : pos_q;
  assign out_u = ack_out ? cnt_full : '0;
  assign cnt_o = CntW'(cnt_full);
  assign data_o = store_q[OutW-1:0];
  assign empty_o = pos_q == '0;
  assign flush_done_o = fsm_q == FlushSend && pos_q == '0;
  // Valid units of the head word form an LSB-aligned run of cnt_o ones
  always_comb begin
    mask_o = '0;
    for (int u = 0; u < NOut; u++) mask_o[u] = u < int'(cnt_o);
  end
  // Merge the accepted fragment and retire the emitted word in the same cycle; empty flush clears all
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q <= '0;
      store_q <= '0;
      fsm_q <= FlushIdle;
    end else if (flush_done_o) begin
      pos_q <= '0;
      store_q <= '0;
      fsm_q <= FlushIdle;
    end else begin
      pos_q <= pos_q + (ack_in ? n_in : '0) - out_u;
      store_q <= (ack_in ? merged : store_q) >> (int'(out_u) * UnitW);
      if (flush_i && fsm_q == FlushIdle) fsm_q <= FlushSend;
    end
  end
`ifdef PRIM_UNIT_PACKER_MASK_CHECK_EN
  logic err_q;
  // A mask with more than one run of ones has more than two edges; latch it until reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else if (ack_in && unit_popcount(MaxU'(mask_i ^ (mask_i << 1))) > 2) err_q <= 1'b1;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
  // A stalled head word must hold still, and the pointer never exceeds the storage
  assert property (@(posedge clk_i) disable iff (!rst_ni) valid_o && !ready_i |=> $stable(data_o) && $stable(cnt_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) pos_q <= PtrW'(StoreU));
endmodule

// File: tb/tb_prim_unit_packer.sv
// tb_prim_unit_packer: randomized and directed checks of prim_unit_packer against a byte-queue model
module tb_prim_unit_packer;
  logic clk_i = 1'b0, rst_ni = 1'b0, valid_i = 1'b0, ready_i = 1'b0, flush_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [3:0] mask_i = '0;
  logic ready_o, valid_o, flush_done_o, empty_o, err_o;
  logic [31:0] data_o;
  logic [3:0] mask_o;
  logic [2:0] cnt_o;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;
  logic [7:0] q[$];
  bit m_fl = 1'b0, m_err = 1'b0;

  prim_unit_packer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .data_i(data_i), .mask_i(mask_i),
    .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .mask_o(mask_o), .cnt_o(cnt_o),
    .ready_i(ready_i), .flush_i(flush_i), .flush_done_o(flush_done_o), .empty_o(empty_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: storage is a FIFO of units; the head word is its first min(size,4) units
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q.delete();
      m_fl = 1'b0;
      m_err = 1'b0;
    end else begin
      automatic int sz = q.size();
      automatic bit rdy = !m_fl && sz <= 8;
      automatic bit vld = sz >= 4 || (m_fl && sz != 0);
      if (m_fl && sz == 0) m_fl = 1'b0;
      else begin
        if (vld && ready_i) for (int i = 0; i < (sz < 4 ? sz : 4); i++) void'(q.pop_front());
        if (valid_i && rdy) begin
          for (int u = 0; u < 4; u++) if (mask_i[u]) q.push_back(data_i[u*8 +: 8]);
`ifdef PRIM_UNIT_PACKER_MASK_CHECK_EN
          if ($countones(mask_i ^ (mask_i << 1)) > 2) m_err = 1'b1;
`endif
        end
        if (flush_i) m_fl = 1'b1;
      end
    end
  end

  // Compare every output against the model each cycle
  always @(negedge clk_i) begin
    if (chk_en) begin
      automatic int sz = q.size();
      automatic int n = sz < 4 ? sz : 4;
      automatic logic [31:0] ed = '0;
      for (int i = 0; i < n; i++) ed[i*8 +: 8] = q[i];
      chk("ready_o", ready_o, !m_fl && sz <= 8);
      chk("valid_o", valid_o, sz >= 4 || (m_fl && sz != 0));
      chk("empty_o", empty_o, sz == 0);
      chk("flush_done_o", flush_done_o, m_fl && sz == 0);
      chk("err_o", err_o, m_err);
      chk("cnt_o", cnt_o, n);
      chk("mask_o", mask_o, (64'd1 << n) - 1);
      chk("data_o", data_o, ed);
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] m);
    valid_i = 1'b1;
    data_i = d;
    mask_i = m;
    cyc();
    valid_i = 1'b0;
  endtask

  initial begin
    int acc;
    bit seen;
    repeat (2) @(negedge clk_i);
    chk("rst valid_o", valid_o, 0);
    chk("rst ready_o", ready_o, 1);
    chk("rst empty_o", empty_o, 1);
    chk("rst cnt_o", cnt_o, 0);
    chk("rst err_o", err_o, 0);
    chk("rst flush_done_o", flush_done_o, 0);
    chk("rst data_o", data_o, 0);
    rst_ni = 1'b1;
    chk_en = 1'b1;
    // two half fragments form one word
    ready_i = 1'b1;
    send(32'h0000_2211, 4'b0011);
    send(32'h0000_4433, 4'b0011);
    chk("t2 valid_o", valid_o, 1);
    chk("t2 data_o", data_o, 32'h4433_2211);
    chk("t2 mask_o", mask_o, 4'b1111);
    chk("t2 cnt_o", cnt_o, 4);
    cyc();
    chk("t2 empty_o", empty_o, 1);
    // offset fragment then flush emits a partial word
    send(32'h0033_2200, 4'b0110);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    chk("t3 ready_o", ready_o, 0);
    chk("t3 valid_o", valid_o, 1);
    chk("t3 data_o", data_o, 32'h0000_3322);
    chk("t3 mask_o", mask_o, 4'b0011);
    chk("t3 cnt_o", cnt_o, 2);
    cyc();
    chk("t3 flush_done_o", flush_done_o, 1);
    cyc();
    chk("t3 done pulse", flush_done_o, 0);
    chk("t3 ready_o after", ready_o, 1);
    // backpressure fills storage
    ready_i = 1'b0;
    valid_i = 1'b1;
    mask_i = 4'hf;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      data_i = 32'h1111_1111 * (i + 1);
      if (ready_o) acc++;
      cyc();
    end
    valid_i = 1'b0;
    chk("t4 accepts", acc, 3);
    chk("t4 ready_o", ready_o, 0);
    chk("t4 head", data_o, 32'h1111_1111);
    ready_i = 1'b1;
    cyc();
    chk("t4 word1", data_o, 32'h2222_2222);
    cyc();
    chk("t4 word2", data_o, 32'h3333_3333);
    cyc();
    chk("t4 drained", empty_o, 1);
    // simultaneous accept and emit
    ready_i = 1'b0;
    send(32'hdead_beef, 4'hf);
    ready_i = 1'b1;
    send(32'hcafe_f00d, 4'hf);
    chk("t5 data_o", data_o, 32'hcafe_f00d);
    chk("t5 cnt_o", cnt_o, 4);
    cyc();
    chk("t5 empty_o", empty_o, 1);
    // flush while empty
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    chk("t6 flush_done_o", flush_done_o, 1);
    chk("t6 valid_o", valid_o, 0);
    cyc();
    chk("t6 ready_o", ready_o, 1);
`ifdef PRIM_UNIT_PACKER_MASK_CHECK_EN
    send(32'h0000_00ab, 4'b1001);
    chk("t6 err_o", err_o, 1);
    cyc();
    chk("t6 err sticky", err_o, 1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    repeat (3) cyc();
`endif
    // random traffic with backpressure phases, flushes and a mid-run reset
    for (int c = 0; c < 3000; c++) begin
      automatic int len = $urandom_range(0, 4);
      automatic int st = len == 0 ? 0 : $urandom_range(0, 4 - len);
      automatic int pr = c < 1000 ? 80 : (c < 2000 ? 20 : 50);
      automatic logic [4:0] mm = 5'((32'd1 << len) - 1) << st;
      valid_i = $urandom_range(0, 3) != 0;
      data_i = $urandom;
      mask_i = mm[3:0];
      ready_i = $urandom_range(0, 99) < pr;
      flush_i = $urandom_range(0, 40) == 0;
      if (c == 1500) begin
        #2 rst_ni = 1'b0;
        #1 chk("async rst valid_o", valid_o, 0);
        chk("async rst empty_o", empty_o, 1);
        @(negedge clk_i);
        rst_ni = 1'b1;
      end
      cyc();
    end
    // final drain must complete within a bounded number of cycles
    valid_i = 1'b0;
    ready_i = 1'b1;
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (flush_done_o) seen = 1'b1;
      else cyc();
    end
    chk("drain flush_done", seen, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
